// File: rtl/pool_pkg.sv
// Shared constants and elaboration-time helpers for the streaming pooling engine.
package pool_pkg;

  localparam logic POOL_MODE_MAX = 1'b0;
  localparam logic POOL_MODE_AVG = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Window holds POOL_SIZE^2 samples, so the sum needs 2*log2(P) guard bits.
  function automatic int acc_width(input int dw, input int p);
    return dw + 2 * clog2(p);
  endfunction

endpackage

// File: rtl/pool_combine.sv
// One channel's combine step: seed, running max, or running sum of a window,
// plus the final pooled value derived from the updated accumulator.
module pool_combine
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_W       = 10,
  parameter int SIGNED_DATA = 0
) (
  input  logic [ACC_W-1:0]      entry_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  first_i,
  input  logic                  mode_i,
  output logic [ACC_W-1:0]      acc_o,
  output logic [DATA_WIDTH-1:0] pooled_o
);
  localparam int SH = ACC_W - DATA_WIDTH;

  logic [ACC_W-1:0] ext;
  logic             take;

  if (SIGNED_DATA != 0) begin : g_s
    assign ext  = {{SH{sample_i[DATA_WIDTH-1]}}, sample_i};
    assign take = $signed(ext) > $signed(entry_i);
  end else begin : g_u
    assign ext  = {{SH{1'b0}}, sample_i};
    assign take = ext > entry_i;
  end

  always_comb begin
    acc_o = entry_i;
    if (first_i)                    acc_o = ext;
    else if (mode_i == POOL_MODE_AVG) acc_o = entry_i + ext;
    else if (take)                  acc_o = ext;
  end

  // Low DATA_WIDTH bits of (sum >>> SH) are just the top bits of the sum,
  // so arithmetic vs logical shift makes no difference here; result is floor.
  assign pooled_o = (mode_i == POOL_MODE_AVG) ? acc_o[ACC_W-1:SH] : acc_o[DATA_WIDTH-1:0];

endmodule

// File: rtl/maxpool_stream.sv
// Streaming non-overlapping 2-D max/avg pooling with a per-column partial
// buffer and a single registered output stage.
module maxpool_stream
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int IN_HEIGHT   = 28,
  parameter int IN_WIDTH    = 28,
  parameter int CHANNELS    = 1,
  parameter int POOL_SIZE   = 2,
  parameter int SIGNED_DATA = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mode_avg,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH*CHANNELS-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH*CHANNELS-1:0] out_data,
  output logic                           out_last,
  output logic                           frame_busy
);
  localparam int LOG_P = clog2(POOL_SIZE);
  localparam int ACC_W = acc_width(DATA_WIDTH, POOL_SIZE);
  localparam int OUT_H = IN_HEIGHT / POOL_SIZE;
  localparam int OUT_W = IN_WIDTH / POOL_SIZE;
  localparam int CW    = (clog2(IN_WIDTH) > LOG_P) ? clog2(IN_WIDTH) : LOG_P + 1;
  localparam int RW    = (clog2(IN_HEIGHT) > LOG_P) ? clog2(IN_HEIGHT) : LOG_P + 1;
  localparam int DW    = DATA_WIDTH * CHANNELS;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          mode_q, mode_d, busy_q, busy_d;
  logic          ov_q, ov_d, ol_q, ol_d;
  logic [DW-1:0] od_q, od_d;

  logic [OUT_W-1:0][CHANNELS-1:0][ACC_W-1:0] buf_q;
  logic [CHANNELS-1:0][ACC_W-1:0]            entry_rd, acc;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]       pooled;

  logic [CW-LOG_P-1:0] ocol;
  logic [RW-LOG_P-1:0] orow;
  logic [LOG_P-1:0]    wr, hr;
  logic accept, origin, in_region, first, complete, last_col, last_row, mode_eff;

  assign ocol      = col_q[CW-1:LOG_P];
  assign orow      = row_q[RW-1:LOG_P];
  assign wr        = col_q[LOG_P-1:0];
  assign hr        = row_q[LOG_P-1:0];
  assign in_ready  = !ov_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign origin    = (col_q == '0) && (row_q == '0);
  assign in_region = (32'(col_q) < OUT_W * POOL_SIZE) && (32'(row_q) < OUT_H * POOL_SIZE);
  assign first     = (hr == '0) && (wr == '0);
  assign complete  = in_region && (&hr) && (&wr);
  assign last_col  = 32'(col_q) == IN_WIDTH - 1;
  assign last_row  = 32'(row_q) == IN_HEIGHT - 1;
  // The frame's first beat must already see the new mode, not the stale latch.
  assign mode_eff  = origin ? mode_avg : mode_q;

  always_comb begin
    entry_rd = '0;
    for (int e = 0; e < OUT_W; e++)
      if (32'(ocol) == e) entry_rd = buf_q[e];
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pool_combine #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_W      (ACC_W),
      .SIGNED_DATA(SIGNED_DATA)
    ) u_comb (
      .entry_i (entry_rd[c]),
      .sample_i(in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .first_i (first),
      .mode_i  (mode_eff),
      .acc_o   (acc[c]),
      .pooled_o(pooled[c])
    );
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    mode_d = mode_q;
    busy_d = busy_q;
    ov_d   = ov_q && !out_ready;
    ol_d   = ol_q;
    od_d   = od_q;
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (origin) begin
        mode_d = mode_avg;
        busy_d = 1'b1;
      end
      if (last_col && last_row) busy_d = 1'b0;
      if (complete) begin
        ov_d = 1'b1;
        od_d = pooled;
        ol_d = (32'(ocol) == OUT_W - 1) && (32'(orow) == OUT_H - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= 1'b0;
      busy_q <= 1'b0;
      ov_q   <= 1'b0;
      ol_q   <= 1'b0;
      od_q   <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      mode_q <= mode_d;
      busy_q <= busy_d;
      ov_q   <= ov_d;
      ol_q   <= ol_d;
      od_q   <= od_d;
    end
  end

  // Partials need no reset: each window's first beat overwrites its entry.
  always_ff @(posedge clk) begin
    for (int e = 0; e < OUT_W; e++)
      if (accept && in_region && !complete && 32'(ocol) == e) buf_q[e] <= acc;
  end

  assign out_valid  = ov_q;
  assign out_data   = od_q;
  assign out_last   = ol_q;
  assign frame_busy = busy_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench: three configurations of maxpool_stream driven from vector
// tables, plus hand-written backpressure and mid-frame reset sequences.
module tb_maxpool_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // u0: 4x4, 1 ch, unsigned
  logic m0 = 0, iv0 = 0, ir0, ov0, or0 = 1, ol0, fb0;
  logic [7:0] id0 = 0, od0;
  // u1: 4x4, 2 ch, signed
  logic m1 = 0, iv1 = 0, ir1, ov1, or1 = 1, ol1, fb1;
  logic [15:0] id1 = 0, od1;
  // u2: 5x5, 1 ch, unsigned
  logic m2 = 0, iv2 = 0, ir2, ov2, or2 = 1, ol2, fb2;
  logic [7:0] id2 = 0, od2;

  maxpool_stream #(.DATA_WIDTH(8), .IN_HEIGHT(4), .IN_WIDTH(4), .CHANNELS(1),
                   .POOL_SIZE(2), .SIGNED_DATA(0)) u0 (
    .clk(clk), .rst_n(rst_n), .mode_avg(m0), .in_valid(iv0), .in_ready(ir0),
    .in_data(id0), .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .out_last(ol0), .frame_busy(fb0));

  maxpool_stream #(.DATA_WIDTH(8), .IN_HEIGHT(4), .IN_WIDTH(4), .CHANNELS(2),
                   .POOL_SIZE(2), .SIGNED_DATA(1)) u1 (
    .clk(clk), .rst_n(rst_n), .mode_avg(m1), .in_valid(iv1), .in_ready(ir1),
    .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .out_last(ol1), .frame_busy(fb1));

  maxpool_stream #(.DATA_WIDTH(8), .IN_HEIGHT(5), .IN_WIDTH(5), .CHANNELS(1),
                   .POOL_SIZE(2), .SIGNED_DATA(0)) u2 (
    .clk(clk), .rst_n(rst_n), .mode_avg(m2), .in_valid(iv2), .in_ready(ir2),
    .in_data(id2), .out_valid(ov2), .out_ready(or2), .out_data(od2),
    .out_last(ol2), .frame_busy(fb2));

  typedef struct {
    int          dut;
    logic        vld;
    logic        mode;
    logic [15:0] din;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    logic        eb;
  } vec_t;

  vec_t tv[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input int d, input logic vld, input logic mode,
                              input logic [15:0] din, input logic ev,
                              input logic [15:0] ed, input logic el, input logic eb);
    vec_t v;
    v.dut = d; v.vld = vld; v.mode = mode; v.din = din;
    v.ev = ev; v.ed = ed; v.el = el; v.eb = eb;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    case (v.dut)
      0: begin iv0 = v.vld; m0 = v.mode; id0 = v.din[7:0]; end
      1: begin iv1 = v.vld; m1 = v.mode; id1 = v.din;      end
      default: begin iv2 = v.vld; m2 = v.mode; id2 = v.din[7:0]; end
    endcase
  endtask

  task automatic sample(input int d, output logic r, output logic v,
                        output logic [15:0] dt, output logic l, output logic b);
    case (d)
      0: begin r = ir0; v = ov0; dt = {8'h0, od0}; l = ol0; b = fb0; end
      1: begin r = ir1; v = ov1; dt = od1;         l = ol1; b = fb1; end
      default: begin r = ir2; v = ov2; dt = {8'h0, od2}; l = ol2; b = fb2; end
    endcase
  endtask

  task automatic run_range(input int lo, input int hi);
    logic r, v, l, b;
    logic [15:0] dt;
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      sample(tv[i].dut, r, v, dt, l, b);
      if (tv[i].vld) chk($sformatf("v%0d_in_ready", i), r, 1);
      @(posedge clk);
      #1;
      sample(tv[i].dut, r, v, dt, l, b);
      chk($sformatf("v%0d_out_valid", i), v, tv[i].ev);
      if (tv[i].ev) begin
        chk($sformatf("v%0d_out_data", i), dt, tv[i].ed);
        chk($sformatf("v%0d_out_last", i), l, tv[i].el);
      end
      chk($sformatf("v%0d_frame_busy", i), b, tv[i].eb);
    end
  endtask

  function automatic int win(input int i);
    case (i)
      5: return 0;
      7: return 1;
      13: return 2;
      default: return 3;
    endcase
  endfunction

  byte c0[16] = '{-1, -2, -100, 50, -3, -4, -3, 49, 127, 127, -128, -128, 127, 126, -128, -127};
  byte c1[16] = '{-128, -1, 5, 6, -5, -7, 7, 9, 0, 1, -1, 0, 2, 3, 0, 0};
  logic [15:0] e1avg[4] = '{16'hDCFD, 16'h06FF, 16'h017E, 16'hFF80};
  logic [15:0] e1max[4] = '{16'hFFFF, 16'h0932, 16'h037F, 16'h0081};
  logic [7:0]  e0avg[4] = '{8'd2, 8'd4, 8'd10, 8'd12};

  int p_u0max, p_u2, p_u1, p_u0avg, p_end;

  initial begin
    logic [7:0] gd[$];
    logic       gl[$];
    int b, stall;
    logic seen;
    logic [7:0] exp_bp[4];
    exp_bp = '{8'd5, 8'd7, 8'd13, 8'd15};

    // u0 max frame; mode_avg toggles after beat 0 and must be ignored
    p_u0max = tv.size();
    for (int i = 0; i < 16; i++) begin
      logic e;
      e = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      tv.push_back(mk(0, 1, i != 0, 16'(i), e, 16'(i), i == 15, i != 15));
    end
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    // u2 5x5 max, two frames to show counter wrap
    p_u2 = tv.size();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 25; i++) begin
        logic e;
        e = (i == 6) || (i == 8) || (i == 16) || (i == 18);
        tv.push_back(mk(2, 1, 0, 16'(i), e, 16'(i), i == 18, i != 24));
      end
    tv.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0));
    // u1 signed 2-ch: avg frame then max frame
    p_u1 = tv.size();
    for (int i = 0; i < 16; i++) begin
      logic e;
      e = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      tv.push_back(mk(1, 1, i == 0, {c1[i], c0[i]}, e, e1avg[win(i)], i == 15, i != 15));
    end
    for (int i = 0; i < 16; i++) begin
      logic e;
      e = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      tv.push_back(mk(1, 1, i != 0, {c1[i], c0[i]}, e, e1max[win(i)], i == 15, i != 15));
    end
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    // u0 avg frame, used right after the mid-frame reset
    p_u0avg = tv.size();
    for (int i = 0; i < 16; i++) begin
      logic e;
      e = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      tv.push_back(mk(0, 1, i == 0, 16'(i), e, 16'(e0avg[win(i)]), i == 15, i != 15));
    end
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    p_end = tv.size();

    // reset state
    #1;
    chk("rst_out_valid", {ov0, ov1, ov2}, 0);
    chk("rst_in_ready", {ir0, ir1, ir2}, 3'b111);
    chk("rst_busy", {fb0, fb1, fb2}, 0);
    chk("rst_data", {od0, od1, od2}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_range(p_u0max, p_u2);
    run_range(p_u2, p_u1);
    run_range(p_u1, p_u0avg);

    // backpressure on u0: stall 6 cycles after the first result
    b = 0; stall = 0; seen = 0;
    for (int cyc = 0; cyc < 200 && gd.size() < 4; cyc++) begin
      @(negedge clk);
      seen = seen | ov0;
      if (seen && stall < 6) begin or0 = 0; stall++; end
      else or0 = 1;
      iv0 = (b < 16); id0 = 8'(b); m0 = 0;
      #1;
      if (ov0 && !or0) chk("bp_stalled_in_ready", ir0, 0);
      if (!ov0) chk("bp_free_in_ready", ir0, 1);
      if (ov0 && or0) begin gd.push_back(od0); gl.push_back(ol0); end
      if (iv0 && ir0) b++;
    end
    @(negedge clk);
    iv0 = 0; or0 = 1;
    chk("bp_result_count", gd.size(), 4);
    chk("bp_beats_accepted", b, 16);
    chk("bp_stall_cycles", stall, 6);
    for (int k = 0; k < 4 && k < gd.size(); k++) begin
      chk($sformatf("bp_data%0d", k), gd[k], exp_bp[k]);
      chk($sformatf("bp_last%0d", k), gl[k], k == 3);
    end

    // mid-frame reset with out_valid held high
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      or0 = 0; iv0 = 1; id0 = 8'(i); m0 = 0;
    end
    @(negedge clk);
    iv0 = 0;
    #1;
    chk("mid_pre_out_valid", ov0, 1);
    chk("mid_pre_busy", fb0, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", ov0, 0);
    chk("mid_rst_in_ready", ir0, 1);
    chk("mid_rst_busy", fb0, 0);
    chk("mid_rst_data_last", {od0, ol0}, 0);
    @(negedge clk);
    rst_n = 1'b1; or0 = 1;
    run_range(p_u0avg, p_end);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxpool_stream.md
Name: maxpool_stream

Overview:
- Streaming 2-D pooling engine; successor to the flat, whole-frame max-pool stage.
- Accepts one pixel per beat in raster order, all channels packed per beat, over a valid/ready handshake.
- Emits one pooled pixel per beat when its window completes.
- Adds run-time max/average mode, signed data, arbitrary channel count, backpressure, frame-end marking and a per-column partial-result buffer instead of a full-frame register.

Parameters:
DATA_WIDTH, 8, bits per channel sample
IN_HEIGHT, 28, input rows per frame
IN_WIDTH, 28, input columns per frame
CHANNELS, 1, channels packed per beat, ≥1
POOL_SIZE, 2, window edge; stride equals POOL_SIZE (non-overlapping); must be a power of 2, 2..8
SIGNED_DATA, 0, 1 = samples are two's complement for compare and average

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mode_avg  in  1  0 = max, 1 = average; sampled at the first accepted beat of each frame
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  DATA_WIDTH*CHANNELS  channel c at [c*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  1  pooled pixel valid
out_ready  in  1  downstream accepts
out_data  out  DATA_WIDTH*CHANNELS  pooled pixel, same packing as in_data
out_last  out  1  high with the final pooled pixel of a frame
frame_busy  out  1  high from the first accepted beat of a frame until its last input beat is accepted

Behaviour:
- Derived constants:
  - OUT_H = IN_HEIGHT/POOL_SIZE, OUT_W = IN_WIDTH/POOL_SIZE (floor).
  - LOG_P = log2(POOL_SIZE).
  - ACC_W = DATA_WIDTH + 2*LOG_P.
- Counters:
  - col (0..IN_WIDTH-1) and row (0..IN_HEIGHT-1) advance on each accepted beat; col wraps to 0 and increments row; row wraps to 0 at frame end.
  - ocol = col>>LOG_P, wr = col & (POOL_SIZE-1), hr = row & (POOL_SIZE-1).
- Remainder handling: beats with col >= OUT_W*POOL_SIZE or row >= OUT_H*POOL_SIZE are accepted and discarded. They still advance the counters.
- Partial buffer: OUT_W entries × CHANNELS × ACC_W.
  - First beat of a window (hr==0 && wr==0): entry loaded with the sample. Max mode stores it sign- or zero-extended; avg mode stores it extended to ACC_W.
  - Later beats: max mode stores max(entry, sample) using a signed compare when SIGNED_DATA=1, else unsigned. Avg mode stores entry + sample at ACC_W with no overflow possible.
- Window completes on the beat with hr==wr==POOL_SIZE-1 inside the valid region. The combined result is written to the output register (not the buffer).
  - Max: low DATA_WIDTH bits.
  - Avg: accumulated sum >>> 2*LOG_P, arithmetic when signed, i.e. floor.
- Output register:
  - out_valid rises the cycle after the completing beat is accepted (latency 1).
  - Holds out_data/out_last until out_valid && out_ready.
- Backpressure: in_ready = !out_valid || out_ready. This is a single output stage with no input stall otherwise.
  - Completing beat and out handshake in the same cycle: the new result replaces the old one; no bubble, no loss.
- out_last asserts on the pooled pixel for (OUT_H-1, OUT_W-1).
- Mode latch: mode_avg is captured when row==0 && col==0 on acceptance. Changing it mid-frame has no effect until the next frame.
- Reset (rst_n low, any time, including mid-frame or with out_valid high):
  - col, row, out_valid, out_last, out_data, frame_busy and the latched mode all clear to 0.
  - in_ready reads 1 after reset.
  - Buffer contents are don't-care; each window's first beat overwrites its entry.
- Counters start at frame origin after reset; no frame-start input exists.

Decomposition:
- Shared package pool_pkg:
  - POOL_MODE_MAX=0, POOL_MODE_AVG=1.
  - clog2 function.
  - Helper to compute ACC_W.
- One sub-module, pool_combine: per-channel combinational max/add of entry and sample, with a SIGNED_DATA parameter. It is instantiated CHANNELS times via generate.
- Counters, buffer and output register live in the top level.

Test Plan:
- 4×4, 1 channel, max, unsigned; input 0..15 raster, out_ready=1 -> outputs 5,7,13,15; out_last only on 15; each output one cycle after beats 5,7,13,15.
- Same frame, mode_avg=1 -> outputs 2,4,10,12 (sums 10,18,42,50 >>2).
- 4×4, SIGNED_DATA=1, CHANNELS=2, avg:
  - ch0 window {-1,-2,-3,-4} -> -3 (0xFD, floor of -2.5).
  - ch1 max mode window {-128,-1,-5,-7} -> -1 (0xFF).
- 5×5 input, POOL_SIZE=2, values 0..24 -> 4 outputs 6,8,16,18; row/col 4 discarded; 25 beats all accepted.
- Backpressure: hold out_ready=0 after first result -> in_ready drops only once out_valid is high; no beat lost; releasing yields the identical sequence.
- Assert rst_n low mid-frame with out_valid high -> out_valid=0 and in_ready=1 immediately; the next 16-beat frame produces correct results with no stale partials.
